// File: rtl/fp_round_pkg.sv
// Shared encodings for the FP round/pack stage: rounding modes, FSM states,
// per-precision exponent limits and bit positions inside fls/flags.
package fp_round_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RZ  = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rm_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_NORM  = 2'b01,
    ST_ROUND = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int BIAS_D = 1023;
  localparam int BIAS_S = 127;
  localparam logic signed [12:0] EMAX_D = 13'sd2047;
  localparam logic signed [12:0] EMAX_S = 13'sd255;

  localparam int FLS_INV  = 4;
  localparam int FLS_INF  = 3;
  localparam int FLS_NAN  = 2;
  localparam int FLS_ZERO = 1;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

endpackage

// File: rtl/fp_lzc57.sv
// Leading-zero count over the 56 bits below the carry bit of the adder
// significand; an all-zero input reports 56.
module fp_lzc57 (
  input  logic [55:0] a,
  output logic [5:0]  cnt
);

  // Ascending scan: the last hit is the most significant set bit.
  always_comb begin
    cnt = 6'd56;
    for (int i = 0; i < 56; i++) begin
      if (a[i]) cnt = 6'(55 - i);
    end
  end

endmodule

// File: rtl/fp_round_pack.sv
// Round/pack stage behind the FP adder: normalize, round per RM, resolve
// overflow and specials, emit packed double/single with {INV,OVF,UNF,INX}.
module fp_round_pack
  import fp_round_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int SIG_W = 57,
  parameter int FLS_W = 58
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ss,
  input  logic [EXP_W-1:0] es,
  input  logic [SIG_W-1:0] fs,
  input  logic [FLS_W-1:0] fls,
  input  logic [1:0]       RM,
  input  logic             db,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      fp_out,
  output logic [3:0]       flags
);

  function automatic logic round_inc(input rm_e rm, input logic sgn, input logic g,
                                     input logic r, input logic st, input logic lsb);
    logic inx;
    inx = g | r | st;
    case (rm)
      RM_RNE:  round_inc = g & (r | st | lsb);
      RM_RZ:   round_inc = 1'b0;
      RM_RUP:  round_inc = ~sgn & inx;
      default: round_inc = sgn & inx;
    endcase
  endfunction

  function automatic logic ovf_to_inf(input rm_e rm, input logic sgn);
    ovf_to_inf = (rm == RM_RNE) || (rm == RM_RUP && !sgn) || (rm == RM_RDN && sgn);
  endfunction

  state_e                  state_q, state_d;
  logic                    ss_q, ss_d;
  rm_e                     rm_q, rm_d;
  logic                    db_q, db_d;
  logic [FLS_W-1:0]        fls_q, fls_d;
  logic [SIG_W-1:0]        sig_q, sig_d;
  logic signed [12:0]      exp_q, exp_d;
  logic                    tiny_q, tiny_d;
  logic [63:0]             fp_out_q, fp_out_d;
  logic [3:0]              flags_q, flags_d;

  logic [5:0]              lz;
  logic signed [12:0]      lz_s;
  logic [SIG_W-1:0]        nsig;
  logic signed [12:0]      nexp;
  logic                    ntiny;

  logic [51:0]             frac;
  logic [52:0]             frac_sum;
  logic                    g, r, st, inx, inc, carry, ovf;
  logic signed [12:0]      exp_r, emax;
  logic [63:0]             res;
  logic [3:0]              flg;

  logic                    unused_fls;
  assign unused_fls = ^{fls_q[57], fls_q[5], fls_q[0]};

  fp_lzc57 u_lzc (
    .a   (sig_q[55:0]),
    .cnt (lz)
  );

  // NORM: bring the leading one to bit 55, or stop at exponent 1 when tiny.
  always_comb begin
    lz_s  = signed'({7'd0, lz});
    nsig  = sig_q;
    nexp  = exp_q;
    ntiny = 1'b0;
    if (sig_q[56]) begin
      nsig = {1'b0, sig_q[56:2], sig_q[1] | sig_q[0]};
      nexp = exp_q + 13'sd1;
    end else if (exp_q <= 13'sd0) begin
      nsig  = {1'b0, sig_q[56:2], sig_q[1] | sig_q[0]};
      nexp  = 13'sd0;
      ntiny = 1'b1;
    end else if ((exp_q - lz_s) < 13'sd1) begin
      nsig  = sig_q << 6'(exp_q - 13'sd1);
      nexp  = 13'sd0;
      ntiny = 1'b1;
    end else begin
      nsig = sig_q << lz;
      nexp = exp_q - lz_s;
    end
  end

  // ROUND: a fraction carry ripples into the exponent, which also lifts a denormal to exp 1.
  always_comb begin
    frac = '0;
    g    = 1'b0;
    r    = 1'b0;
    st   = 1'b0;
    if (db_q) begin
      frac = sig_q[54:3];
      g    = sig_q[2];
      r    = sig_q[1];
      st   = sig_q[0];
    end else begin
      frac = {29'd0, sig_q[54:32]};
      g    = sig_q[31];
      r    = sig_q[30];
      st   = |sig_q[29:0];
    end
    inx      = g | r | st;
    inc      = round_inc(rm_q, ss_q, g, r, st, frac[0]);
    frac_sum = {1'b0, frac} + {52'd0, inc};
    carry    = db_q ? frac_sum[52] : frac_sum[23];
    exp_r    = exp_q + (carry ? 13'sd1 : 13'sd0);
    emax     = db_q ? EMAX_D : EMAX_S;
    ovf      = exp_r >= emax;

    res = '0;
    flg = '0;
    if (fls_q[FLS_NAN]) begin
      res = db_q ? {ss_q, 11'h7FF, 1'b1, fls_q[56:6]}
                 : {32'd0, ss_q, 8'hFF, 1'b1, fls_q[56:35]};
      flg[FLG_INV] = fls_q[FLS_INV];
    end else if (fls_q[FLS_INF]) begin
      res = db_q ? {ss_q, 11'h7FF, 52'd0} : {32'd0, ss_q, 8'hFF, 23'd0};
    end else if (fls_q[FLS_ZERO] || sig_q == '0) begin
      res = db_q ? {ss_q, 63'd0} : {32'd0, ss_q, 31'd0};
    end else if (ovf) begin
      flg[FLG_OVF] = 1'b1;
      flg[FLG_INX] = 1'b1;
      if (ovf_to_inf(rm_q, ss_q))
        res = db_q ? {ss_q, 11'h7FF, 52'd0} : {32'd0, ss_q, 8'hFF, 23'd0};
      else
        res = db_q ? {ss_q, 11'h7FE, {52{1'b1}}} : {32'd0, ss_q, 8'hFE, {23{1'b1}}};
    end else begin
      res = db_q ? {ss_q, exp_r[10:0], frac_sum[51:0]}
                 : {32'd0, ss_q, exp_r[7:0], frac_sum[22:0]};
      flg[FLG_UNF] = tiny_q & inx;
      flg[FLG_INX] = inx;
    end
  end

  always_comb begin
    state_d  = state_q;
    ss_d     = ss_q;
    rm_d     = rm_q;
    db_d     = db_q;
    fls_d    = fls_q;
    sig_d    = sig_q;
    exp_d    = exp_q;
    tiny_d   = tiny_q;
    fp_out_d = fp_out_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ss_d    = ss;
          rm_d    = rm_e'(RM);
          db_d    = db;
          fls_d   = fls;
          sig_d   = fs;
          exp_d   = signed'(13'(es));
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        sig_d   = nsig;
        exp_d   = nexp;
        tiny_d  = ntiny;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        fp_out_d = res;
        flags_d  = flg;
        state_d  = ST_DONE;
      end
      default: begin
        if (out_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ss_q     <= 1'b0;
      rm_q     <= RM_RNE;
      db_q     <= 1'b0;
      fls_q    <= '0;
      sig_q    <= '0;
      exp_q    <= '0;
      tiny_q   <= 1'b0;
      fp_out_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      ss_q     <= ss_d;
      rm_q     <= rm_d;
      db_q     <= db_d;
      fls_q    <= fls_d;
      sig_q    <= sig_d;
      exp_q    <= exp_d;
      tiny_q   <= tiny_d;
      fp_out_q <= fp_out_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign fp_out    = fp_out_q;
  assign flags     = flags_q;

endmodule
